// File: rtl/controller_rtl_29.sv
// Eight-state Moore sequencing controller steered by status inputs x, y, E, F.
// The binary state register `state` is the only observable output; the
// surrounding datapath probes it hierarchically.
module controller_rtl_29 (
    input  logic clock,
    input  logic reset,
    input  logic x,
    input  logic y,
    input  logic E,
    input  logic F
);

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] S0 = STATE_W'(0);
    localparam logic [STATE_W-1:0] S1 = STATE_W'(1);
    localparam logic [STATE_W-1:0] S2 = STATE_W'(2);
    localparam logic [STATE_W-1:0] S3 = STATE_W'(3);
    localparam logic [STATE_W-1:0] S4 = STATE_W'(4);
    localparam logic [STATE_W-1:0] S5 = STATE_W'(5);
    localparam logic [STATE_W-1:0] S6 = STATE_W'(6);
    localparam logic [STATE_W-1:0] S7 = STATE_W'(7);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;

    // Next-state decode; any unknown encoding falls back to S0.
    always_comb begin
        next_state = S0;
        case (state)
            S0: begin
                if (x) begin
                    next_state = S1;
                end else if (y) begin
                    next_state = S2;
                end else begin
                    next_state = S0;
                end
            end
            S1: next_state = S2;
            S2: next_state = F ? S3 : S4;
            S3: next_state = S0;
            S4: next_state = E ? S5 : S6;
            S5: next_state = S0;
            S6: next_state = S7;
            S7: next_state = S0;
            default: next_state = S0;
        endcase
    end

    // State register with asynchronous active-low reset to S0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S0;
        end else begin
            state <= next_state;
        end
    end

endmodule

// File: tb/tb_controller_rtl_29.sv
// Scoreboard bench for controller_rtl_29: stimulus pushes expected states,
// an independent monitor pops and compares after each rising edge.
module tb_controller_rtl_29;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic x = 1'b0;
    logic y = 1'b0;
    logic E = 1'b0;
    logic F = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;
    int ref_s  = 0;

    logic [2:0] expq[$];

    always #5 clock = ~clock;

    controller_rtl_29 dut (
        .clock(clock),
        .reset(reset),
        .x(x),
        .y(y),
        .E(E),
        .F(F)
    );

    // Reference: successor state taken straight from the transition rules.
    function automatic int ref_next(int s, bit xi, bit yi, bit ei, bit fi);
        case (s)
            0:       return xi ? 1 : (yi ? 2 : 0);
            1:       return 2;
            2:       return fi ? 3 : 4;
            4:       return ei ? 5 : 6;
            6:       return 7;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: state=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom_range(1, 0));
    endfunction

    // Apply inputs for one cycle and queue the state expected after the edge.
    task automatic drive(input bit xi, input bit yi, input bit ei, input bit fi, input int exp);
        @(negedge clock);
        x = xi; y = yi; E = ei; F = fi;
        ref_s = exp;
        expq.push_back(3'(exp));
        @(posedge clock);
    endtask

    // Monitor: compare the state register just after each rising edge.
    always @(posedge clock) begin
        logic [2:0] e;
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("seq", dut.state, e);
        end
    end

    initial begin
        bit rx, ry, re, rf;
        int nx;

        // Reset held low: state must sit at S0 across edges.
        repeat (2) @(negedge clock);
        check("reset_hold", dut.state, 3'd0);
        @(negedge clock);
        x = 1'b1;
        @(negedge clock);
        check("reset_ignores_x", dut.state, 3'd0);
        reset = 1'b1;
        x = 1'b0;

        // Idle with x=0, y=0.
        drive(0, 0, rb(), rb(), 0);
        drive(0, 0, rb(), rb(), 0);

        // Path A: 0,1,2,4,5,0 with don't-cares randomised.
        drive(1, rb(), rb(), rb(), 1);
        drive(rb(), rb(), rb(), rb(), 2);
        drive(rb(), rb(), rb(), 0, 4);
        drive(rb(), rb(), 1, rb(), 5);
        drive(rb(), rb(), rb(), rb(), 0);

        // Path B: 0,2,3,0 then idle for three clocks.
        drive(0, 1, rb(), rb(), 2);
        drive(rb(), rb(), rb(), 1, 3);
        drive(rb(), rb(), rb(), rb(), 0);
        repeat (3) drive(0, 0, rb(), rb(), 0);

        // Path C: 0,2,4,6,7,0 with E random in S6/S7.
        drive(0, 1, rb(), rb(), 2);
        drive(rb(), rb(), rb(), 0, 4);
        drive(rb(), rb(), 0, rb(), 6);
        drive(rb(), rb(), rb(), rb(), 7);
        drive(rb(), rb(), rb(), rb(), 0);

        // Priority: x dominates y in S0.
        drive(1, 1, rb(), rb(), 1);
        drive(rb(), rb(), rb(), 1, 2);
        drive(rb(), rb(), rb(), 1, 3);
        drive(rb(), rb(), rb(), rb(), 0);

        // Asynchronous reset in S6, between edges.
        drive(0, 1, rb(), rb(), 2);
        drive(rb(), rb(), rb(), 0, 4);
        drive(rb(), rb(), 0, rb(), 6);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset", dut.state, 3'd0);
        repeat (3) begin
            @(negedge clock);
            x = rb(); y = rb();
            check("reset_low_hold", dut.state, 3'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        x = 1'b0; y = 1'b0;
        ref_s = 0;
        repeat (3) drive(0, 0, rb(), rb(), 0);

        // Recovery: corrupt the register between edges, expect S0 next edge.
        @(negedge clock);
        force dut.state = 3'd7;
        #1;
        release dut.state;
        x = 1'b0; y = 1'b0;
        ref_s = 0;
        expq.push_back(3'd0);
        @(posedge clock);
        drive(0, 0, rb(), rb(), 0);

        // Randomised run against the reference model.
        repeat (400) begin
            rx = rb(); ry = rb(); re = rb(); rf = rb();
            if ($urandom_range(3, 0) == 0) rx = 1'b0;
            nx = ref_next(ref_s, rx, ry, re, rf);
            drive(rx, ry, re, rf, nx);
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && expq.size() > 0; i++) @(posedge clock);
        #2;
        n_cmp++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending=%0d expected=0", expq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
